// File: rtl/tpm_axil_pkg.sv
// Shared types and constants for the AXI4-Lite transaction master.
package tpm_axil_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StWrAddrData,
    StWrResp,
    StRdAddr,
    StRdData,
    StDone
  } state_e;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  localparam int unsigned TimeoutW = 8;

  function automatic logic resp_is_err(logic [1:0] resp);
    return (resp == AXI_RESP_SLVERR) || (resp == AXI_RESP_DECERR);
  endfunction

endpackage

// File: rtl/tpm_axil_txn_master_if.sv
// AXI4-Lite bus bundle between the transaction master and its target slave.
interface tpm_axil_txn_master_if #(
  parameter int unsigned DataWidth = 32
) ();
  logic [31:0]            M_AXI_AWADDR;
  logic [2:0]             M_AXI_AWPROT;
  logic                   M_AXI_AWVALID;
  logic                   M_AXI_AWREADY;
  logic [DataWidth-1:0]   M_AXI_WDATA;
  logic [DataWidth/8-1:0] M_AXI_WSTRB;
  logic                   M_AXI_WVALID;
  logic                   M_AXI_WREADY;
  logic [1:0]             M_AXI_BRESP;
  logic                   M_AXI_BVALID;
  logic                   M_AXI_BREADY;
  logic [31:0]            M_AXI_ARADDR;
  logic [2:0]             M_AXI_ARPROT;
  logic                   M_AXI_ARVALID;
  logic                   M_AXI_ARREADY;
  logic [DataWidth-1:0]   M_AXI_RDATA;
  logic [1:0]             M_AXI_RRESP;
  logic                   M_AXI_RVALID;
  logic                   M_AXI_RREADY;

  modport master (
    output M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
           M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID, M_AXI_RREADY,
    input  M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID, M_AXI_ARREADY,
           M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );

  modport slave (
    input  M_AXI_AWADDR, M_AXI_AWPROT, M_AXI_AWVALID, M_AXI_WDATA, M_AXI_WSTRB, M_AXI_WVALID,
           M_AXI_BREADY, M_AXI_ARADDR, M_AXI_ARPROT, M_AXI_ARVALID, M_AXI_RREADY,
    output M_AXI_AWREADY, M_AXI_WREADY, M_AXI_BRESP, M_AXI_BVALID, M_AXI_ARREADY,
           M_AXI_RDATA, M_AXI_RRESP, M_AXI_RVALID
  );

endinterface

// File: rtl/tpm_axil_txn_master.sv
// AXI4-Lite master: writes idx+1 to N consecutive words, reads them back and flags mismatches.
// Optional wait-state watchdog enabled by defining TPM_AXIL_TIMEOUT_EN.
module tpm_axil_txn_master
  import tpm_axil_pkg::*;
#(
  parameter logic [31:0] C_M_TARGET_SLAVE_BASE_ADDR = 32'h4000_0000,
  parameter int unsigned C_M_AXI_DATA_WIDTH         = 32,
  parameter int unsigned C_M_TRANSACTIONS_NUM       = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  INIT_AXI_TXN,
  output logic                  TXN_DONE,
  output logic                  ERROR,
  tpm_axil_txn_master_if.master m_axi
);

  localparam logic [4:0] LastIdx = 5'(C_M_TRANSACTIONS_NUM - 1);

  typedef logic [C_M_AXI_DATA_WIDTH-1:0] data_t;

  function automatic logic [31:0] idx_addr(logic [4:0] i);
    return C_M_TARGET_SLAVE_BASE_ADDR + {25'b0, i, 2'b00};
  endfunction

  function automatic data_t idx_data(logic [4:0] i);
    return C_M_AXI_DATA_WIDTH'(i) + C_M_AXI_DATA_WIDTH'(1);
  endfunction

  state_e      state_q;
  logic [4:0]  idx_q;
  logic        init_q, done_q, err_q;
  logic        awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic [31:0] awaddr_q, araddr_q;
  data_t       wdata_q;
  logic        init_pulse, timeout;

  assign init_pulse = INIT_AXI_TXN && !init_q;

`ifdef TPM_AXIL_TIMEOUT_EN
  state_e              prev_q;
  logic [TimeoutW-1:0] tmo_q;
  logic                wait_st;

  assign wait_st = state_q inside {StWrAddrData, StWrResp, StRdAddr, StRdData};
  assign timeout = wait_st && (tmo_q == '1);

  // Counter restarts whenever the FSM has just moved to a new state.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      prev_q <= StIdle;
      tmo_q  <= '0;
    end else begin
      prev_q <= state_q;
      if (state_q != prev_q || !wait_st) tmo_q <= '0;
      else if (tmo_q != '1)              tmo_q <= tmo_q + 1'b1;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q   <= StIdle;
      idx_q     <= '0;
      init_q    <= 1'b0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      awaddr_q  <= '0;
      araddr_q  <= '0;
      wdata_q   <= '0;
    end else begin
      init_q <= INIT_AXI_TXN;
      if (timeout) begin
        err_q     <= 1'b1;
        done_q    <= 1'b1;
        awvalid_q <= 1'b0;
        wvalid_q  <= 1'b0;
        bready_q  <= 1'b0;
        arvalid_q <= 1'b0;
        rready_q  <= 1'b0;
        state_q   <= StDone;
      end else begin
        unique case (state_q)
          StIdle, StDone: begin
            if (init_pulse) begin
              done_q    <= 1'b0;
              err_q     <= 1'b0;
              idx_q     <= '0;
              awaddr_q  <= idx_addr(5'd0);
              wdata_q   <= idx_data(5'd0);
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= StWrAddrData;
            end
          end
          StWrAddrData: begin
            if (awvalid_q && m_axi.M_AXI_AWREADY) awvalid_q <= 1'b0;
            if (wvalid_q && m_axi.M_AXI_WREADY)   wvalid_q  <= 1'b0;
            if ((!awvalid_q || m_axi.M_AXI_AWREADY) && (!wvalid_q || m_axi.M_AXI_WREADY)) begin
              bready_q <= 1'b1;
              state_q  <= StWrResp;
            end
          end
          StWrResp: begin
            if (m_axi.M_AXI_BVALID) begin
              bready_q <= 1'b0;
              if (resp_is_err(m_axi.M_AXI_BRESP)) err_q <= 1'b1;
              if (idx_q == LastIdx) begin
                idx_q     <= '0;
                araddr_q  <= idx_addr(5'd0);
                arvalid_q <= 1'b1;
                state_q   <= StRdAddr;
              end else begin
                idx_q     <= idx_q + 5'd1;
                awaddr_q  <= idx_addr(idx_q + 5'd1);
                wdata_q   <= idx_data(idx_q + 5'd1);
                awvalid_q <= 1'b1;
                wvalid_q  <= 1'b1;
                state_q   <= StWrAddrData;
              end
            end
          end
          StRdAddr: begin
            if (m_axi.M_AXI_ARREADY) begin
              arvalid_q <= 1'b0;
              rready_q  <= 1'b1;
              state_q   <= StRdData;
            end
          end
          StRdData: begin
            if (m_axi.M_AXI_RVALID) begin
              rready_q <= 1'b0;
              if (m_axi.M_AXI_RDATA != idx_data(idx_q) || resp_is_err(m_axi.M_AXI_RRESP)) begin
                err_q <= 1'b1;
              end
              if (idx_q == LastIdx) begin
                done_q  <= 1'b1;
                state_q <= StDone;
              end else begin
                idx_q     <= idx_q + 5'd1;
                araddr_q  <= idx_addr(idx_q + 5'd1);
                arvalid_q <= 1'b1;
                state_q   <= StRdAddr;
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign TXN_DONE            = done_q;
  assign ERROR               = err_q;
  assign m_axi.M_AXI_AWADDR  = awaddr_q;
  assign m_axi.M_AXI_AWPROT  = 3'b000;
  assign m_axi.M_AXI_AWVALID = awvalid_q;
  assign m_axi.M_AXI_WDATA   = wdata_q;
  assign m_axi.M_AXI_WSTRB   = '1;
  assign m_axi.M_AXI_WVALID  = wvalid_q;
  assign m_axi.M_AXI_BREADY  = bready_q;
  assign m_axi.M_AXI_ARADDR  = araddr_q;
  assign m_axi.M_AXI_ARPROT  = 3'b000;
  assign m_axi.M_AXI_ARVALID = arvalid_q;
  assign m_axi.M_AXI_RREADY  = rready_q;

endmodule

// File: tb/tb_tpm_axil_txn_master.sv
// Scoreboard bench for tpm_axil_txn_master: reactive slave, expected-queue monitor.
module tb_tpm_axil_txn_master;
  import tpm_axil_pkg::*;

  localparam logic [31:0] Base = 32'h4000_0000;

  typedef struct {
    logic err;
    int   nwr;
    int   nrd;
  } done_exp_t;

  logic clk, areset, init, done, err;
  tpm_axil_txn_master_if #(.DataWidth(32)) bus ();

  tpm_axil_txn_master #(
    .C_M_TARGET_SLAVE_BASE_ADDR(Base),
    .C_M_AXI_DATA_WIDTH        (32),
    .C_M_TRANSACTIONS_NUM      (4)
  ) dut (
    .ACLK        (clk),
    .ARESET      (areset),
    .INIT_AXI_TXN(init),
    .TXN_DONE    (done),
    .ERROR       (err),
    .m_axi       (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_aw[$];
  logic [31:0] exp_w[$];
  logic [31:0] exp_ar[$];
  done_exp_t   exp_done[$];

  int aw_delay        = 0;
  bit corrupt_rd      = 0;
  bit bresp_err_first = 0;
  bit no_bresp        = 0;
  int wr_seen         = 0;
  int rd_seen         = 0;
  bit w_early         = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic flag_fail(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // Reactive slave, driven on the falling edge
  int          aw_cnt = 0;
  logic [31:0] ridx;
  initial begin
    bus.M_AXI_AWREADY = 1'b0;
    bus.M_AXI_WREADY  = 1'b0;
    bus.M_AXI_BVALID  = 1'b0;
    bus.M_AXI_BRESP   = AXI_RESP_OKAY;
    bus.M_AXI_ARREADY = 1'b0;
    bus.M_AXI_RVALID  = 1'b0;
    bus.M_AXI_RDATA   = '0;
    bus.M_AXI_RRESP   = AXI_RESP_OKAY;
    forever begin
      @(negedge clk);
      aw_cnt            = bus.M_AXI_AWVALID ? aw_cnt + 1 : 0;
      bus.M_AXI_AWREADY = bus.M_AXI_AWVALID && (aw_cnt > aw_delay);
      bus.M_AXI_WREADY  = bus.M_AXI_WVALID;
      bus.M_AXI_BVALID  = bus.M_AXI_BREADY && !no_bresp;
      bus.M_AXI_BRESP   = (bresp_err_first && wr_seen == 0) ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
      bus.M_AXI_ARREADY = bus.M_AXI_ARVALID;
      bus.M_AXI_RVALID  = bus.M_AXI_RREADY;
      ridx              = (bus.M_AXI_ARADDR - Base) >> 2;
      bus.M_AXI_RDATA   = (corrupt_rd && ridx == 32'd2) ? 32'h5 : ridx + 32'd1;
      bus.M_AXI_RRESP   = AXI_RESP_OKAY;
    end
  end

  // Monitor: samples 2 time units after the slave drives, well before the rising edge
  bit pend_aw = 0, pend_w = 0, pend_ar = 0, done_prev = 0;
  always begin
    @(negedge clk);
    #2;
    if (areset) begin
      pend_aw   = 0;
      pend_w    = 0;
      pend_ar   = 0;
      done_prev = 0;
    end else begin
      if (pend_aw) check("awvalid_hold", {31'b0, bus.M_AXI_AWVALID}, 32'd1);
      if (pend_w)  check("wvalid_hold", {31'b0, bus.M_AXI_WVALID}, 32'd1);
      if (pend_ar) check("arvalid_hold", {31'b0, bus.M_AXI_ARVALID}, 32'd1);
      if (bus.M_AXI_AWVALID && !bus.M_AXI_WVALID) w_early = 1;
      if (bus.M_AXI_AWVALID && bus.M_AXI_AWREADY) begin
        if (exp_aw.size() == 0) flag_fail("aw_unexpected");
        else check("awaddr", bus.M_AXI_AWADDR, exp_aw.pop_front());
      end
      if (bus.M_AXI_WVALID && bus.M_AXI_WREADY) begin
        check("wstrb", {28'b0, bus.M_AXI_WSTRB}, 32'hF);
        if (exp_w.size() == 0) flag_fail("w_unexpected");
        else check("wdata", bus.M_AXI_WDATA, exp_w.pop_front());
      end
      if (bus.M_AXI_ARVALID && bus.M_AXI_ARREADY) begin
        if (exp_ar.size() == 0) flag_fail("ar_unexpected");
        else check("araddr", bus.M_AXI_ARADDR, exp_ar.pop_front());
      end
      if (bus.M_AXI_BVALID && bus.M_AXI_BREADY) wr_seen++;
      if (bus.M_AXI_RVALID && bus.M_AXI_RREADY) rd_seen++;
      if (done && !done_prev) begin
        if (exp_done.size() == 0) flag_fail("done_unexpected");
        else begin
          done_exp_t e;
          e = exp_done.pop_front();
          check("done_error", {31'b0, err}, {31'b0, e.err});
          check("done_writes", wr_seen, e.nwr);
          check("done_reads", rd_seen, e.nrd);
        end
      end
      done_prev = done;
      pend_aw   = bus.M_AXI_AWVALID && !bus.M_AXI_AWREADY;
      pend_w    = bus.M_AXI_WVALID && !bus.M_AXI_WREADY;
      pend_ar   = bus.M_AXI_ARVALID && !bus.M_AXI_ARREADY;
    end
  end

  task automatic push_run(input logic e);
    for (int i = 0; i < 4; i++) begin
      exp_aw.push_back(Base + 32'(4 * i));
      exp_w.push_back(32'(i + 1));
      exp_ar.push_back(Base + 32'(4 * i));
    end
    exp_done.push_back('{e, 4, 4});
  endtask

  task automatic start_run();
    wr_seen = 0;
    rd_seen = 0;
    @(negedge clk);
    #3 init = 1'b1;
    @(negedge clk);
    #3 init = 1'b0;
  endtask

  task automatic wait_done(input int bound, input string name);
    int n = 0;
    while (!done && n < bound) begin
      @(negedge clk);
      #3;
      n++;
    end
    if (!done) flag_fail({name, "_timeout"});
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
    check({tag, "_error"}, {31'b0, err}, 32'd0);
    check({tag, "_awvalid"}, {31'b0, bus.M_AXI_AWVALID}, 32'd0);
    check({tag, "_wvalid"}, {31'b0, bus.M_AXI_WVALID}, 32'd0);
    check({tag, "_bready"}, {31'b0, bus.M_AXI_BREADY}, 32'd0);
    check({tag, "_arvalid"}, {31'b0, bus.M_AXI_ARVALID}, 32'd0);
    check({tag, "_rready"}, {31'b0, bus.M_AXI_RREADY}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    areset = 1'b1;
    init   = 1'b0;
    repeat (3) @(negedge clk);
    #3 check_idle_outputs("reset");
    areset = 1'b0;
    repeat (2) @(negedge clk);

    // Zero-wait slave
    push_run(1'b0);
    start_run();
    wait_done(200, "zero_wait");

    // AW accepted 3 cycles after W
    aw_delay = 3;
    w_early  = 0;
    push_run(1'b0);
    start_run();
    wait_done(300, "aw_delay");
    check("w_drops_before_aw", {31'b0, w_early}, 32'd1);
    aw_delay = 0;

    // Corrupted read data at idx 2
    corrupt_rd = 1;
    push_run(1'b1);
    start_run();
    wait_done(200, "rd_corrupt");
    check("rd_corrupt_done_hold", {31'b0, done}, 32'd1);
    corrupt_rd = 0;

    // SLVERR on the first write response
    bresp_err_first = 1;
    push_run(1'b1);
    start_run();
    wait_done(200, "bresp_err");
    bresp_err_first = 0;

    // Reset while waiting for read data, then a clean run
    push_run(1'b0);
    start_run();
    n = 0;
    while (!bus.M_AXI_RREADY && n < 200) begin
      @(negedge clk);
      #3;
      n++;
    end
    check("reached_rd_data", {31'b0, bus.M_AXI_RREADY}, 32'd1);
    areset = 1'b1;
    @(negedge clk);
    #3 check_idle_outputs("midrun_reset");
    exp_aw.delete();
    exp_w.delete();
    exp_ar.delete();
    exp_done.delete();
    areset = 1'b0;
    @(negedge clk);
    push_run(1'b0);
    start_run();
    wait_done(200, "after_reset");

`ifdef TPM_AXIL_TIMEOUT_EN
    // Slave never answers the first write
    no_bresp = 1;
    exp_aw.push_back(Base);
    exp_w.push_back(32'd1);
    exp_done.push_back('{1'b1, 0, 0});
    start_run();
    n = 0;
    while (!bus.M_AXI_BREADY && n < 50) begin
      @(negedge clk);
      #3;
      n++;
    end
    check("tmo_reached_wr_resp", {31'b0, bus.M_AXI_BREADY}, 32'd1);
    n = 0;
    while (!done && n < 400) begin
      @(negedge clk);
      #3;
      n++;
    end
    check("tmo_window", {31'b0, (n >= 250 && n <= 262)}, 32'd1);
    check("tmo_bready_drop", {31'b0, bus.M_AXI_BREADY}, 32'd0);
    check("tmo_error", {31'b0, err}, 32'd1);
    no_bresp = 0;
`endif

    repeat (3) @(negedge clk);
    check("aw_queue_empty", 32'(exp_aw.size()), 32'd0);
    check("w_queue_empty", 32'(exp_w.size()), 32'd0);
    check("ar_queue_empty", 32'(exp_ar.size()), 32'd0);
    check("done_queue_empty", 32'(exp_done.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tpm_axil_txn_master.md
TPM_AXIL_TXN_MASTER -- requirements
Module: tpm_axil_txn_master

Interface
REQ-001 SHALL use a single clock ACLK; reset ARESET SHALL be synchronous and active-high.
REQ-002 Parameter C_M_TARGET_SLAVE_BASE_ADDR, default 32'h4000_0000, base byte address of the target slave.
REQ-003 Parameter C_M_AXI_DATA_WIDTH, default 32, data width; only 32 is supported.
REQ-004 Parameter C_M_TRANSACTIONS_NUM, default 4, writes per run and reads per run; legal range 1..16.
REQ-005 ACLK  input  1  clock; all logic on the rising edge.
REQ-006 ARESET  input  1  synchronous active-high reset.
REQ-007 INIT_AXI_TXN  input  1  start request; a rising edge starts a run.
REQ-008 TXN_DONE  output  1  run complete (level).
REQ-009 ERROR  output  1  sticky run error.
REQ-010 M_AXI_AWADDR  output  32  write address.
REQ-011 M_AXI_AWPROT / M_AXI_ARPROT  output  3 each  tied to 3'b000.
REQ-012 M_AXI_AWVALID / M_AXI_AWREADY  output / input  1  write-address handshake.
REQ-013 M_AXI_WDATA  output  32  write data.
REQ-014 M_AXI_WSTRB  output  4  tied to 4'hF.
REQ-015 M_AXI_WVALID / M_AXI_WREADY  output / input  1  write-data handshake.
REQ-016 M_AXI_BRESP  input  2  write response.
REQ-017 M_AXI_BVALID / M_AXI_BREADY  input / output  1  write-response handshake.
REQ-018 M_AXI_ARADDR  output  32  read address.
REQ-019 M_AXI_ARVALID / M_AXI_ARREADY  output / input  1  read-address handshake.
REQ-020 M_AXI_RDATA  input  32  read data.
REQ-021 M_AXI_RRESP  input  2  read response.
REQ-022 M_AXI_RVALID / M_AXI_RREADY  input / output  1  read-data handshake.

Function
REQ-023 FSM states: IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE; index counter idx runs 0..C_M_TRANSACTIONS_NUM-1.
REQ-024 INIT edge: registered INIT_AXI_TXN with edge detect; an edge in IDLE or DONE clears TXN_DONE, ERROR and idx and enters WR_ADDR_DATA the next cycle; edges seen in any other state are ignored.
REQ-025 Write: address = base + 4*idx, data = idx+1; AWVALID and WVALID rise together and each drops independently on its own handshake; once both handshakes are done, go to WR_RESP.
REQ-026 WR_RESP: BREADY=1; when BVALID is high, BRESP[1]=1 sets ERROR; then idx++ and go to WR_ADDR_DATA, or after the last write clear idx and go to RD_ADDR.
REQ-027 Read: RD_ADDR holds ARVALID until ARREADY; RD_DATA holds RREADY=1; when RVALID is high, RDATA != idx+1 or RRESP[1]=1 sets ERROR; last read goes to DONE.
REQ-028 One outstanding transaction at a time; VALID signals SHALL NOT drop before their handshake.
REQ-029 DONE: TXN_DONE=1 and ERROR hold until the next INIT edge or reset; a compare error does not abort the run.

Reset
REQ-030 ARESET forces IDLE, idx=0, all VALID/READY outputs 0, TXN_DONE=0, ERROR=0 and the edge register to 0; reset mid-transaction abandons the transaction without completing it.

Configuration
REQ-031 With TPM_AXIL_TIMEOUT_EN defined, an 8-bit counter cleared on each state change counts cycles in every wait state; on reaching 255, ERROR=1, all VALID/READY outputs drop and the FSM goes to DONE. Without the macro, the FSM waits indefinitely.

Structure
REQ-032 Package tpm_axil_pkg SHALL hold the FSM state enum, AXI_RESP_OKAY/SLVERR/DECERR constants and the timeout width constant; no sub-module is required.

Verification
REQ-033 Zero-wait slave, INIT pulse -> 4 writes to 0x4000_0000..0x4000_000C with data 1..4, 4 matching reads, TXN_DONE=1, ERROR=0.
REQ-034 AWREADY delayed 3 cycles after WREADY -> WVALID drops after its handshake, AWVALID holds until its own handshake; run still passes.
REQ-035 Slave returns RDATA=0x5 at idx 2 -> ERROR=1, all 4 reads still issued, TXN_DONE=1.
REQ-036 BRESP=2'b10 on the first write -> ERROR=1 at DONE.
REQ-037 ARESET asserted during RD_DATA, then INIT pulse -> outputs reset to 0 and a clean full run passes.
REQ-038 With TPM_AXIL_TIMEOUT_EN, BVALID never asserted -> 255 cycles later ERROR=1 and TXN_DONE=1.
